// File: rtl/gcd_seq_driver.sv
// gcd_seq_driver: on-chip self-test initiator for one gcd core.
// Pulls operand/expected vectors from a valid/ready stream. For each vector it
// pulses the core's reset with the operands applied and waits for core_valid,
// with a timeout. It keeps saturating pass/fail counts and records the first
// failing vector of the run.
module gcd_seq_driver #(
  parameter int unsigned W       = 14,
  parameter int unsigned RST_CYC = 2,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TO_W    = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [W-1:0]     vec_a,
  input  logic [W-1:0]     vec_b,
  input  logic [W-1:0]     vec_exp,
  input  logic             vec_last,
  output logic             core_nrst,
  output logic [W-1:0]     core_a,
  output logic [W-1:0]     core_b,
  input  logic [W-1:0]     core_gcd,
  input  logic             core_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             timeout,
  output logic [W-1:0]     fail_a,
  output logic [W-1:0]     fail_b,
  output logic [W-1:0]     fail_exp,
  output logic [W-1:0]     fail_got
);

  // One counter is shared by the CRST and GAP phases, so it is sized for the longer one.
  localparam int unsigned CYC_MAX  = (RST_CYC > GAP_CYC) ? RST_CYC : GAP_CYC;
  localparam int unsigned CYC_W    = (CYC_MAX < 2) ? 1 : $clog2(CYC_MAX);
  localparam int unsigned RST_LAST = RST_CYC - 1;
  localparam int unsigned GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CRST,
    S_RUN,
    S_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [W-1:0]     exp_q, exp_d;
  logic             last_q, last_d;
  logic             core_nrst_q, core_nrst_d;
  logic [W-1:0]     core_a_q, core_a_d;
  logic [W-1:0]     core_b_q, core_b_d;
  logic             vec_ready_q, vec_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             timeout_q, timeout_d;
  logic [W-1:0]     fail_a_q, fail_a_d;
  logic [W-1:0]     fail_b_q, fail_b_d;
  logic [W-1:0]     fail_exp_q, fail_exp_d;
  logic [W-1:0]     fail_got_q, fail_got_d;

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      to_q        <= '0;
      exp_q       <= '0;
      last_q      <= 1'b0;
      core_nrst_q <= 1'b0;
      core_a_q    <= '0;
      core_b_q    <= '0;
      vec_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      to_q        <= to_d;
      exp_q       <= exp_d;
      last_q      <= last_d;
      core_nrst_q <= core_nrst_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      vec_ready_q <= vec_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      timeout_q   <= timeout_d;
      fail_a_q    <= fail_a_d;
      fail_b_q    <= fail_b_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
    end
  end

  // Next-state, run bookkeeping, and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    to_d       = to_q;
    exp_d      = exp_q;
    last_d     = last_q;
    core_a_d   = core_a_q;
    core_b_d   = core_b_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    timeout_d  = timeout_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_exp_d = fail_exp_q;
    fail_got_d = fail_got_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          timeout_d  = 1'b0;
          fail_a_d   = '0;
          fail_b_d   = '0;
          fail_exp_d = '0;
          fail_got_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (vec_valid && vec_ready_q) begin
          core_a_d = vec_a;
          core_b_d = vec_b;
          exp_d    = vec_exp;
          last_d   = vec_last;
          cyc_d    = '0;
          state_d  = S_CRST;
        end
      end
      S_CRST: begin
        if (cyc_q == CYC_W'(RST_LAST)) begin
          to_d    = '0;
          state_d = S_RUN;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_RUN: begin
        // A result on the final timeout cycle still counts as a result.
        if (core_valid || (to_q == '1)) begin
          if (core_valid && (core_gcd == exp_q)) begin
            if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
          end else begin
            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
            if (!core_valid) timeout_d = 1'b1;
            // fail_cnt is cleared at start, so zero means no failure yet this run.
            if (fail_cnt_q == '0) begin
              fail_a_d   = core_a_q;
              fail_b_d   = core_b_q;
              fail_exp_d = exp_q;
              fail_got_d = core_valid ? core_gcd : '0;
            end
          end
          cyc_d = '0;
          if (GAP_CYC == 0) state_d = last_q ? S_DONE : S_FETCH;
          else              state_d = S_GAP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_GAP: begin
        if (cyc_q == CYC_W'(GAP_LAST)) state_d = last_q ? S_DONE : S_FETCH;
        else                           cyc_d   = cyc_q + CYC_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    core_nrst_d = (state_d == S_RUN);
    vec_ready_d = (state_d == S_FETCH);
    busy_d      = (state_d == S_FETCH) || (state_d == S_CRST) ||
                  (state_d == S_RUN)   || (state_d == S_GAP);
    done_d      = (state_d == S_DONE);
  end

  assign vec_ready = vec_ready_q;
  assign core_nrst = core_nrst_q;
  assign core_a    = core_a_q;
  assign core_b    = core_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign timeout   = timeout_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;

endmodule

// File: tb/tb_gcd_seq_driver.sv
// Bench for gcd_seq_driver: vector source, behavioural gcd core, and scoreboards
// for per-vector operands and per-run results.
module tb_gcd_seq_driver;

  localparam int unsigned W        = 14;
  localparam int unsigned RST_CYC  = 2;
  localparam int unsigned GAP_CYC  = 2;
  localparam int unsigned TO_W     = 4;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned CORE_LAT = 10;

  logic             clk = 1'b0;
  logic             nrst, start;
  logic             vec_valid, vec_ready, vec_last;
  logic [W-1:0]     vec_a, vec_b, vec_exp;
  logic             core_nrst, core_valid;
  logic [W-1:0]     core_a, core_b, core_gcd;
  logic             busy, done, timeout;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic [W-1:0]     fail_a, fail_b, fail_exp, fail_got;

  gcd_seq_driver #(.W(W), .RST_CYC(RST_CYC), .GAP_CYC(GAP_CYC), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst), .start(start),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_a(vec_a), .vec_b(vec_b),
    .vec_exp(vec_exp), .vec_last(vec_last),
    .core_nrst(core_nrst), .core_a(core_a), .core_b(core_b),
    .core_gcd(core_gcd), .core_valid(core_valid),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .timeout(timeout), .fail_a(fail_a), .fail_b(fail_b),
    .fail_exp(fail_exp), .fail_got(fail_got)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] a, b, e; logic last; } vec_t;
  typedef struct { logic [W-1:0] a, b; } ops_t;
  typedef struct {
    int pass_n, fail_n; logic to;
    logic [W-1:0] fa, fb, fe, fg;
  } res_t;

  vec_t src_q[$];
  ops_t op_q[$];
  res_t res_q[$];

  int n_vec = 0;
  int n_err = 0;
  int stall_gap = 0;
  int stall_left = 0;
  logic stale = 1'b0;
  logic hang = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != '0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Behavioural core: result CORE_LAT cycles after reset release; optional hang and stale valid.
  logic [4:0]   m_cnt;
  logic [W-1:0] m_res;
  logic         m_valid;
  always @(posedge clk) begin
    if (!core_nrst) m_cnt <= 5'd0;
    else if (m_cnt != 5'd31) m_cnt <= m_cnt + 5'd1;
    m_res <= gcd_f(core_a, core_b);
  end
  assign m_valid    = core_nrst && !hang && (32'(m_cnt) >= CORE_LAT);
  assign core_valid = m_valid || (stale && !core_nrst);
  assign core_gcd   = m_valid ? m_res : '0;

  // Vector source; the stall counts only cycles in which the driver is ready.
  initial begin
    vec_valid = 1'b0; vec_a = '0; vec_b = '0; vec_exp = '0; vec_last = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_left != 0) begin
        vec_valid = 1'b0;
        if (vec_ready) stall_left--;
      end else if (src_q.size() != 0) begin
        vec_a = src_q[0].a; vec_b = src_q[0].b; vec_exp = src_q[0].e; vec_last = src_q[0].last;
        vec_valid = 1'b1;
        if (vec_ready) begin
          void'(src_q.pop_front());
          stall_left = stall_gap;
        end
      end else begin
        vec_valid = 1'b0;
      end
    end
  end

  // Operand monitor: on each core_nrst rise, check operands and their stable-low length.
  initial begin
    logic prev_n;
    logic [W-1:0] la, lb;
    int lowcnt;
    ops_t o;
    prev_n = 1'b0; la = '0; lb = '0; lowcnt = 0;
    forever begin
      @(negedge clk);
      if (core_nrst === 1'b1 && prev_n === 1'b0) begin
        if (op_q.size() == 0) begin
          check("unexpected_core_start", 32'(core_a), 32'hFFFF_FFFF);
        end else begin
          o = op_q.pop_front();
          check("core_a", 32'(core_a), 32'(o.a));
          check("core_b", 32'(core_b), 32'(o.b));
          check("crst_len", 32'(lowcnt), 32'(RST_CYC));
        end
      end
      if (core_nrst === 1'b0) begin
        if (core_a == la && core_b == lb) lowcnt++;
        else lowcnt = 1;
      end
      la = core_a; lb = core_b; prev_n = core_nrst;
    end
  end

  // Run monitor: on each rise of done, compare the run summary against the scoreboard.
  initial begin
    logic prev_d;
    res_t r;
    prev_d = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && prev_d !== 1'b1) begin
        if (res_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          r = res_q.pop_front();
          check("pass_cnt", 32'(pass_cnt), 32'(r.pass_n));
          check("fail_cnt", 32'(fail_cnt), 32'(r.fail_n));
          check("timeout",  32'(timeout),  32'(r.to));
          check("fail_a",   32'(fail_a),   32'(r.fa));
          check("fail_b",   32'(fail_b),   32'(r.fb));
          check("fail_exp", 32'(fail_exp), 32'(r.fe));
          check("fail_got", 32'(fail_got), 32'(r.fg));
          check("busy_at_done", 32'(busy), 32'd0);
          check("core_nrst_at_done", 32'(core_nrst), 32'd0);
        end
      end
      prev_d = done;
    end
  end

  task automatic push_vec(input int a, input int b, input int e, input logic last);
    vec_t v;
    ops_t o;
    v.a = W'(a); v.b = W'(b); v.e = W'(e); v.last = last;
    o.a = W'(a); o.b = W'(b);
    src_q.push_back(v);
    op_q.push_back(o);
  endtask

  task automatic push_res(input int p, input int f, input logic to,
                          input int fa, input int fb, input int fe, input int fg);
    res_t r;
    r.pass_n = p; r.fail_n = f; r.to = to;
    r.fa = W'(fa); r.fb = W'(fb); r.fe = W'(fe); r.fg = W'(fg);
    res_q.push_back(r);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) return;
      @(posedge clk); #1;
    end
    check({name, "_done_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic wait_core_rise(input string name);
    int k;
    k = 0;
    while (core_nrst !== 1'b0 && k < 500) begin @(posedge clk); #1; k++; end
    while (core_nrst !== 1'b1 && k < 500) begin @(posedge clk); #1; k++; end
    if (k >= 500) check({name, "_core_start_timeout"}, 32'(core_nrst), 32'd1);
  endtask

  task automatic check_reset(input string name);
    check({name, "_core_nrst"}, 32'(core_nrst), 32'd0);
    check({name, "_core_a"},    32'(core_a),    32'd0);
    check({name, "_core_b"},    32'(core_b),    32'd0);
    check({name, "_vec_ready"}, 32'(vec_ready), 32'd0);
    check({name, "_busy"},      32'(busy),      32'd0);
    check({name, "_done"},      32'(done),      32'd0);
    check({name, "_pass_cnt"},  32'(pass_cnt),  32'd0);
    check({name, "_fail_cnt"},  32'(fail_cnt),  32'd0);
    check({name, "_timeout"},   32'(timeout),   32'd0);
    check({name, "_fail_a"},    32'(fail_a),    32'd0);
    check({name, "_fail_b"},    32'(fail_b),    32'd0);
    check({name, "_fail_exp"},  32'(fail_exp),  32'd0);
    check({name, "_fail_got"},  32'(fail_got),  32'd0);
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    nrst = 1'b1;

    // Single passing vector.
    push_vec(48, 18, 6, 1'b1);
    push_res(1, 0, 1'b0, 0, 0, 0, 0);
    pulse_start(); wait_done("single");

    // Mismatch: core yields 1, vector expects 2.
    push_vec(17, 5, 2, 1'b1);
    push_res(0, 1, 1'b0, 17, 5, 2, 1);
    pulse_start(); wait_done("mismatch");

    // Three vectors, source stalls 5 ready cycles between each.
    stall_gap = 5;
    push_vec(48, 18, 6, 1'b0);
    push_vec(100, 75, 25, 1'b0);
    push_vec(13, 13, 13, 1'b1);
    push_res(3, 0, 1'b0, 0, 0, 0, 0);
    pulse_start(); wait_done("stalled3");
    stall_gap = 0;

    // Core never answers: timeout.
    hang = 1'b1;
    push_vec(9, 6, 3, 1'b1);
    push_res(0, 1, 1'b1, 9, 6, 3, 0);
    pulse_start(); wait_done("timeout");
    hang = 1'b0;

    // Only the first of two failures is recorded.
    push_vec(10, 4, 2, 1'b0);
    push_vec(12, 8, 3, 1'b0);
    push_vec(9, 3, 2, 1'b1);
    push_res(1, 2, 1'b0, 12, 8, 3, 4);
    pulse_start(); wait_done("firstfail");

    // Five passes saturate the 2-bit pass counter.
    push_vec(8, 4, 4, 1'b0);
    push_vec(6, 9, 3, 1'b0);
    push_vec(14, 21, 7, 1'b0);
    push_vec(5, 10, 5, 1'b0);
    push_vec(27, 18, 9, 1'b1);
    push_res(3, 0, 1'b0, 0, 0, 0, 0);
    pulse_start(); wait_done("saturate");

    // Reset during RUN of the second vector aborts the run.
    push_vec(48, 18, 6, 1'b0);
    push_vec(100, 75, 25, 1'b1);
    pulse_start();
    wait_core_rise("abort1");
    wait_core_rise("abort2");
    repeat (3) @(posedge clk);
    #1 nrst = 1'b0;
    @(posedge clk);
    #1 check_reset("abort");
    src_q.delete(); op_q.delete(); stall_left = 0;
    @(posedge clk); #1 nrst = 1'b1;

    // Restart from zero: stale core_valid during CRST and start during RUN are ignored.
    stale = 1'b1;
    push_vec(60, 48, 12, 1'b0);
    push_vec(21, 14, 7, 1'b1);
    push_res(2, 0, 1'b0, 0, 0, 0, 0);
    pulse_start();
    wait_core_rise("stale");
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("stale");
    stale = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check("runs_left", 32'(res_q.size()), 32'd0);
    check("vectors_left", 32'(op_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
